// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Brief    : Game Boy IF/IE registers with edge capture and a prioritised
//            request/acknowledge handshake towards the CPU core.
// Revision : 1.0 - initial release
// ============================================================================

module interrupt_controller #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  input  logic [15:0] I_ADDR,
  inout  wire  [7:0]  IO_DATA,
  input  logic        I_RE_L,
  input  logic        I_WE_L,
  input  logic        I_VBLANK_INT,
  input  logic        I_LCDSTAT_INT,
  input  logic        I_TIMER_INT,
  input  logic        I_SERIAL_INT,
  input  logic        I_JOYPAD_INT,
  input  logic        I_INT_ACK,
  output logic        O_INT_REQ,
  output logic [7:0]  O_INT_VECTOR,
  output logic [7:0]  O_IF_DATA,
  output logic [7:0]  O_IE_DATA
);

  localparam int         c_NUM_SRC  = 5;
  localparam logic [7:0] c_VEC_BASE = 8'h40;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_idx;
  logic [c_NUM_SRC-1:0]   r_if;
  logic [7:0]             r_ie;
  logic [c_NUM_SRC-1:0]   r_prev;

  logic [c_NUM_SRC-1:0]   w_src;
  logic [c_NUM_SRC-1:0]   w_edge;
  logic [c_NUM_SRC-1:0]   w_pending;
  logic [c_NUM_SRC-1:0]   w_if_next;
  logic [7:0]             w_if_rd;
  logic [2:0]             w_pend_idx;
  logic                   w_pend_any;
  logic                   w_if_sel;
  logic                   w_ie_sel;
  logic                   w_wr_if;
  logic                   w_wr_ie;
  logic                   w_rd_if;
  logic                   w_rd_ie;
  logic                   w_ack;
  logic                   w_latched_live;

  assign w_src    = {I_JOYPAD_INT, I_SERIAL_INT, I_TIMER_INT, I_LCDSTAT_INT, I_VBLANK_INT};
  assign w_edge   = w_src & ~r_prev;

  assign w_if_sel = (I_ADDR == IF_ADDR);
  assign w_ie_sel = (I_ADDR == IE_ADDR);
  assign w_wr_if  = ~I_WE_L & w_if_sel;
  assign w_wr_ie  = ~I_WE_L & w_ie_sel;
  assign w_rd_if  = ~I_RE_L & w_if_sel;
  assign w_rd_ie  = ~I_RE_L & w_ie_sel;

  assign w_if_rd  = {3'b111, r_if};
  assign IO_DATA  = w_rd_if ? w_if_rd : (w_rd_ie ? r_ie : 8'bzzzz_zzzz);

  assign O_IF_DATA = w_if_rd;
  assign O_IE_DATA = r_ie;

  assign w_pending      = r_if & r_ie[c_NUM_SRC-1:0];
  assign w_pend_any     = |w_pending;
  assign w_ack          = (r_state == ST_REQ) & I_INT_ACK;
  assign w_latched_live = r_if[r_idx] & r_ie[r_idx];

  // Scan downwards so the lowest set bit (highest priority) is the last write.
  always_comb begin
    w_pend_idx = 3'd0;
    for (int i = c_NUM_SRC - 1; i >= 0; i--) begin
      if (w_pending[i]) begin
        w_pend_idx = 3'(i);
      end
    end
  end

  // IF update order: bus write, then ack clear, then source-edge set.
  always_comb begin
    w_if_next = r_if;
    if (w_wr_if) begin
      w_if_next = IO_DATA[c_NUM_SRC-1:0];
    end
    if (w_ack) begin
      w_if_next[r_idx] = 1'b0;
    end
    w_if_next = w_if_next | w_edge;
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      r_if   <= '0;
      r_ie   <= 8'h00;
      r_prev <= '0;
    end else begin
      r_if   <= w_if_next;
      r_prev <= w_src;
      if (w_wr_ie) begin
        r_ie <= IO_DATA;
      end
    end
  end

  // Request handshake; the latched index is frozen for the whole request.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      r_state      <= ST_IDLE;
      r_idx        <= 3'd0;
      O_INT_REQ    <= 1'b0;
      O_INT_VECTOR <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          O_INT_REQ <= 1'b0;
          if (w_pend_any) begin
            r_idx        <= w_pend_idx;
            O_INT_VECTOR <= c_VEC_BASE + {2'b00, w_pend_idx, 3'b000};
            O_INT_REQ    <= 1'b1;
            r_state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (I_INT_ACK || !w_latched_live) begin
            O_INT_REQ <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            O_INT_REQ <= 1'b1;
          end
        end
        default: begin
          O_INT_REQ <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Brief    : Directed and randomized checks of interrupt_controller against
//            a behavioural IF/IE and request model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_interrupt_controller;

  localparam logic [15:0] c_IF = 16'hFF0F;
  localparam logic [15:0] c_IE = 16'hFFFF;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [15:0] addr  = 16'h0000;
  logic        re_l  = 1'b1;
  logic        we_l  = 1'b1;
  logic        drv   = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        vb = 1'b0, lcd = 1'b0, tim = 1'b0, ser = 1'b0, joy = 1'b0;
  logic        ack = 1'b0;
  wire  [7:0]  io_data;
  logic        req;
  logic [7:0]  vec, ifd, ied;

  int errors = 0;
  int checks = 0;

  assign io_data = drv ? wdata : 8'bzzzz_zzzz;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .I_CLOCK      (clk),
    .I_RESET      (rst),
    .I_ADDR       (addr),
    .IO_DATA      (io_data),
    .I_RE_L       (re_l),
    .I_WE_L       (we_l),
    .I_VBLANK_INT (vb),
    .I_LCDSTAT_INT(lcd),
    .I_TIMER_INT  (tim),
    .I_SERIAL_INT (ser),
    .I_JOYPAD_INT (joy),
    .I_INT_ACK    (ack),
    .O_INT_REQ    (req),
    .O_INT_VECTOR (vec),
    .O_IF_DATA    (ifd),
    .O_IE_DATA    (ied)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdata = d; drv = 1'b1; we_l = 1'b0;
    step();
    we_l = 1'b1; drv = 1'b0; addr = 16'h0000;
  endtask

  // Behavioural model: IF bits, IE byte, a "request outstanding" flag and
  // the source number it refers to.
  logic [4:0] m_if   = 5'd0;
  logic [4:0] m_prev = 5'd0;
  logic [7:0] m_ie   = 8'd0;
  logic [7:0] m_vec  = 8'd0;
  logic       m_req  = 1'b0;
  int         m_src  = 0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [4:0] src, nif, pend;
    logic [7:0] nie;
    int         sel;
    if (rst) begin
      m_if = 5'd0; m_prev = 5'd0; m_ie = 8'd0; m_vec = 8'd0;
      m_req = 1'b0; m_src = 0; m_valid = 1'b1;
    end else begin
      src = {joy, ser, tim, lcd, vb};
      nif = m_if;
      nie = m_ie;
      if (!we_l && addr == c_IF) nif = wdata[4:0];
      if (!we_l && addr == c_IE) nie = wdata;
      if (m_req && ack) nif[m_src] = 1'b0;
      for (int i = 0; i < 5; i++) if (src[i] && !m_prev[i]) nif[i] = 1'b1;
      if (!m_req) begin
        pend = m_if & m_ie[4:0];
        sel = -1;
        for (int i = 0; i < 5; i++) if (pend[i] && sel < 0) sel = i;
        if (sel >= 0) begin
          m_req = 1'b1;
          m_src = sel;
          m_vec = 8'(64 + 8 * sel);
        end
      end else if (ack) begin
        m_req = 1'b0;
      end else if (!m_if[m_src] || !m_ie[m_src]) begin
        m_req = 1'b0;
      end
      m_if = nif;
      m_ie = nie;
      m_prev = src;
    end
  end

  always @(negedge clk) begin : compare
    if (m_valid) begin
      chk("req", {7'd0, req}, {7'd0, m_req});
      chk("vector", vec, m_vec);
      chk("if_dbg", ifd, {3'b111, m_if});
      chk("ie_dbg", ied, m_ie);
      if (!re_l && !drv && addr == c_IF) chk("if_read", io_data, {3'b111, m_if});
      if (!re_l && !drv && addr == c_IE) chk("ie_read", io_data, m_ie);
    end
  end

  int cnt;
  int r;

  initial begin
    step(); step();
    rst = 1'b0;
    addr = c_IF; re_l = 1'b0;
    @(negedge clk);
    chk("rst_if_rd", io_data, 8'hE0);
    chk("rst_req", {7'd0, req}, 8'h00);
    chk("rst_vec", vec, 8'h00);
    chk("rst_if_dbg", ifd, 8'hE0);
    step();
    addr = c_IE;
    @(negedge clk);
    chk("rst_ie_rd", io_data, 8'h00);
    step();
    re_l = 1'b1; addr = 16'h0000;

    // Timer pulse with IE=04
    bus_write(c_IE, 8'h04);
    tim = 1'b1; step(); tim = 1'b0;
    addr = c_IF; re_l = 1'b0;
    @(negedge clk);
    chk("tim_if_n1", io_data, 8'hE4);
    step();
    re_l = 1'b1; addr = 16'h0000;
    @(negedge clk);
    chk("tim_req_n2", {7'd0, req}, 8'h01);
    chk("tim_vec_n2", vec, 8'h50);
    ack = 1'b1; step(); ack = 1'b0;
    @(negedge clk);
    chk("tim_ack_if", ifd, 8'hE0);
    chk("tim_ack_req", {7'd0, req}, 8'h00);
    step();

    // VBlank and joypad together: priority then second service
    bus_write(c_IE, 8'h1F);
    vb = 1'b1; joy = 1'b1; step(); vb = 1'b0; joy = 1'b0;
    step();
    @(negedge clk);
    chk("prio_vec0", vec, 8'h40);
    chk("prio_req0", {7'd0, req}, 8'h01);
    ack = 1'b1; step(); ack = 1'b0;
    @(negedge clk);
    chk("prio_gap", {7'd0, req}, 8'h00);
    step();
    @(negedge clk);
    chk("prio_vec1", vec, 8'h60);
    chk("prio_req1", {7'd0, req}, 8'h01);
    ack = 1'b1; step(); ack = 1'b0;
    @(negedge clk);
    chk("prio_if_end", ifd, 8'hE0);
    step();

    // Masked source, then enable, then withdraw by IF write
    bus_write(c_IE, 8'h00);
    tim = 1'b1; step(); tim = 1'b0;
    @(negedge clk);
    chk("mask_if", ifd, 8'hE4);
    repeat (3) step();
    @(negedge clk);
    chk("mask_noreq", {7'd0, req}, 8'h00);
    bus_write(c_IE, 8'h04);
    @(negedge clk);
    chk("en_req_w1", {7'd0, req}, 8'h00);
    step();
    @(negedge clk);
    chk("en_req_w2", {7'd0, req}, 8'h01);
    chk("en_vec_w2", vec, 8'h50);
    bus_write(c_IF, 8'h00);
    @(negedge clk);
    chk("wd_req_v1", {7'd0, req}, 8'h01);
    step();
    @(negedge clk);
    chk("wd_req_v2", {7'd0, req}, 8'h00);

    // Source edge beats a same-cycle IF write
    addr = c_IF; wdata = 8'h00; drv = 1'b1; we_l = 1'b0; tim = 1'b1;
    step();
    we_l = 1'b1; drv = 1'b0; tim = 1'b0; re_l = 1'b0;
    @(negedge clk);
    chk("set_beats_wr", io_data, 8'hE4);
    step();
    re_l = 1'b1; addr = 16'h0000;
    bus_write(c_IE, 8'h00);
    bus_write(c_IF, 8'h00);
    repeat (4) step();

    // Held joypad level requests once only
    bus_write(c_IE, 8'h10);
    joy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req && !ack) begin
        chk("hold_vec", vec, 8'h60);
        ack = 1'b1;
        cnt++;
      end else begin
        ack = 1'b0;
      end
    end
    ack = 1'b0;
    chk("hold_once", 8'(cnt), 8'd1);
    joy = 1'b0;
    step(); step();
    @(negedge clk);
    chk("hold_released", {7'd0, req}, 8'h00);
    joy = 1'b1;
    step(); step();
    @(negedge clk);
    chk("hold_rearm_req", {7'd0, req}, 8'h01);
    chk("hold_rearm_vec", vec, 8'h60);
    ack = 1'b1; step(); ack = 1'b0; joy = 1'b0;

    // Reset during a request, and a source held across reset release
    bus_write(c_IE, 8'h01);
    vb = 1'b1; step(); vb = 1'b0; step();
    @(negedge clk);
    chk("pre_rst_req", {7'd0, req}, 8'h01);
    rst = 1'b1; vb = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_drop", {7'd0, req}, 8'h00);
    chk("rst_vec_clr", vec, 8'h00);
    chk("rst_ie_clr", ied, 8'h00);
    chk("rst_if_hold0", ifd, 8'hE0);
    step();
    @(negedge clk);
    chk("rst_if_hold1", ifd, 8'hE1);
    vb = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      we_l = 1'b1; re_l = 1'b1; drv = 1'b0; addr = 16'h0000;
      rst  = ($urandom_range(0, 599) == 0);
      vb   = ($urandom_range(0, 5) == 0);
      lcd  = ($urandom_range(0, 5) == 0);
      tim  = ($urandom_range(0, 5) == 0);
      ser  = ($urandom_range(0, 5) == 0);
      joy  = ($urandom_range(0, 5) == 0);
      ack  = ($urandom_range(0, 2) == 0);
      r    = $urandom_range(0, 99);
      wdata = 8'($urandom);
      if (r < 8) begin
        addr = c_IF; we_l = 1'b0; drv = 1'b1;
      end else if (r < 14) begin
        addr = c_IE; we_l = 1'b0; drv = 1'b1;
      end else if (r < 30) begin
        addr = c_IF; re_l = 1'b0;
      end else if (r < 45) begin
        addr = c_IE; re_l = 1'b0;
      end else if (r < 50) begin
        addr = 16'hFF0E; we_l = 1'b0; drv = 1'b1;
      end
      step();
    end
    we_l = 1'b1; re_l = 1'b1; drv = 1'b0; rst = 1'b0; ack = 1'b0;
    {vb, lcd, tim, ser, joy} = 5'd0;
    step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
